branch_resolve: RTL and testbench

Execute-stage branch resolution unit, directly downstream of the static predictor. It compares the prediction carried into EX with the actual branch outcome from the EX comparator. On a mismatch it issues a registered one-shot redirect PC plus IF/ID/EX flush strobes, and blanks the wrong-path instruction that follows. It also keeps saturating counts of resolved branches and mispredictions for performance readout.

---
 rtl/branch_resolve_pkg.sv | 11 +
 rtl/branch_resolve_sat_counter.sv | 19 +
 rtl/branch_resolve.sv | 79 +++++++
 tb/tb_branch_resolve.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/branch_resolve_pkg.sv
// Shared constants and state encoding for the EX-stage branch resolution unit.
package branch_resolve_pkg;

  typedef enum logic {
    BR_IDLE     = 1'b0,
    BR_REDIRECT = 1'b1
  } br_state_e;

  localparam int unsigned INSN_SIZE = 4;

endpackage

// File: rtl/branch_resolve_sat_counter.sv
// Saturating event counter: counts up on inc, sticks at all-ones.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/branch_resolve.sv
// Compares the EX-stage prediction with the actual outcome and issues a
// registered redirect plus flush strobes on a mismatch.
//
// state       | meaning
// BR_IDLE     | resolving branches normally
// BR_REDIRECT | redirect/flush asserted, EX holds a wrong-path instruction
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             PL_stall_ex,
  input  logic             branch_ex,
  input  logic             SP_prediction_result_ex,
  input  logic             branch_taken_ex,
  input  logic [XLEN-1:0]  pc_ex,
  input  logic [XLEN-1:0]  imme_ex,
  output logic             mispredict,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             flush_if,
  output logic             flush_id,
  output logic             flush_ex,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  br_state_e       state, state_nxt;
  logic            resolve;
  logic [XLEN-1:0] target;

  assign resolve    = (state == BR_IDLE) && branch_ex && !PL_stall_ex;
  assign mispredict = resolve && (SP_prediction_result_ex != branch_taken_ex);
  // Sum wraps modulo 2^XLEN by truncation.
  assign target     = pc_ex + (branch_taken_ex ? imme_ex : XLEN'(INSN_SIZE));

  always_comb begin
    state_nxt = state;
    case (state)
      BR_IDLE:     if (mispredict) state_nxt = BR_REDIRECT;
      BR_REDIRECT: if (!PL_stall_ex) state_nxt = BR_IDLE;
      default:     state_nxt = BR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= BR_IDLE;
      redirect_pc <= '0;
    end else begin
      state <= state_nxt;
      if (mispredict) redirect_pc <= target;
    end
  end

  // Strobes are decoded straight from the state register, so they are registered.
  assign redirect_valid = (state == BR_REDIRECT);
  assign flush_if       = redirect_valid;
  assign flush_id       = redirect_valid;
  assign flush_ex       = redirect_valid;

  sat_counter #(.CNT_W(CNT_W)) u_branch_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (resolve),
    .count (branch_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_mispredict_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (mispredict),
    .count (mispredict_count)
  );

endmodule

// File: tb/tb_branch_resolve.sv
// Scoreboard bench for branch_resolve: driver + reference model push expected
// post-edge outputs, a monitor pops and compares each cycle.
module tb_branch_resolve;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             PL_stall_ex;
  logic             branch_ex;
  logic             SP_prediction_result_ex;
  logic             branch_taken_ex;
  logic [XLEN-1:0]  pc_ex;
  logic [XLEN-1:0]  imme_ex;
  logic             mispredict;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;
  logic             flush_if, flush_id, flush_ex;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] mispredict_count;

  branch_resolve #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .PL_stall_ex             (PL_stall_ex),
    .branch_ex               (branch_ex),
    .SP_prediction_result_ex (SP_prediction_result_ex),
    .branch_taken_ex         (branch_taken_ex),
    .pc_ex                   (pc_ex),
    .imme_ex                 (imme_ex),
    .mispredict              (mispredict),
    .redirect_valid          (redirect_valid),
    .redirect_pc             (redirect_pc),
    .flush_if                (flush_if),
    .flush_id                (flush_id),
    .flush_ex                (flush_ex),
    .branch_count            (branch_count),
    .mispredict_count        (mispredict_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rv;
    logic [31:0] pc;
    int          bc;
    int          mc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model state
  bit          m_known = 0;
  bit          m_redir = 0;
  logic [31:0] m_pc    = '0;
  int          m_bc    = 0;
  int          m_mc    = 0;

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
  endtask

  task automatic cycle(input bit rst, input bit stall, input bit br, input bit pred,
                       input bit tkn, input logic [31:0] pc, input logic [31:0] imm);
    bit          exp_mp;
    bit          res;
    longint      sum;
    exp_t        e;
    @(negedge clk);
    rst_n = rst; PL_stall_ex = stall; branch_ex = br;
    SP_prediction_result_ex = pred; branch_taken_ex = tkn;
    pc_ex = pc; imme_ex = imm;
    #1;
    res    = m_known && !m_redir && br && !stall;
    exp_mp = res && (pred != tkn);
    if (m_known) check("mispredict", longint'(mispredict), longint'(exp_mp));
    if (!rst) begin
      m_known = 1; m_redir = 0; m_pc = '0; m_bc = 0; m_mc = 0;
    end else if (m_known) begin
      if (m_redir) begin
        if (!stall) m_redir = 0;
      end else if (exp_mp) begin
        sum     = longint'(pc) + (tkn ? longint'(imm) : 64'd4);
        m_pc    = sum[31:0];
        m_redir = 1;
      end
      if (res)    m_bc = (m_bc < CMAX) ? m_bc + 1 : CMAX;
      if (exp_mp) m_mc = (m_mc < CMAX) ? m_mc + 1 : CMAX;
    end
    if (m_known) begin
      e.rv = m_redir; e.pc = m_pc; e.bc = m_bc; e.mc = m_mc;
      exp_q.push_back(e);
    end
  endtask

  // Monitor: the DUT presents a fresh registered output set every edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("redirect_valid", longint'(redirect_valid), longint'(e.rv));
        check("flush_if", longint'(flush_if), longint'(e.rv));
        check("flush_id", longint'(flush_id), longint'(e.rv));
        check("flush_ex", longint'(flush_ex), longint'(e.rv));
        check("redirect_pc", longint'(redirect_pc), longint'(e.pc));
        check("branch_count", longint'(branch_count), longint'(e.bc));
        check("mispredict_count", longint'(mispredict_count), longint'(e.mc));
      end
    end
  end

  initial begin
    rst_n = 0; PL_stall_ex = 0; branch_ex = 1; SP_prediction_result_ex = 0;
    branch_taken_ex = 1; pc_ex = '0; imme_ex = '0;

    cycle(0, 0, 1, 0, 1, 32'h0, 32'h0);
    cycle(0, 0, 1, 0, 1, 32'h0, 32'h0);
    cycle(1, 0, 0, 0, 0, 32'h0, 32'h0);
    // Correct prediction
    cycle(1, 0, 1, 1, 1, 32'h100, 32'h20);
    cycle(1, 0, 0, 0, 0, 32'h0, 32'h0);
    // Predicted NT, actual T, negative offset
    cycle(1, 0, 1, 0, 1, 32'h100, 32'hFFFF_FFF0);
    cycle(1, 0, 0, 0, 0, 32'h0, 32'h0);
    cycle(1, 0, 0, 0, 0, 32'h0, 32'h0);
    // Predicted T, actual NT with wrap; mismatching branch during REDIRECT ignored
    cycle(1, 0, 1, 1, 0, 32'hFFFF_FFFC, 32'h40);
    cycle(1, 0, 1, 0, 1, 32'h200, 32'h8);
    cycle(1, 0, 0, 0, 0, 32'h0, 32'h0);
    // Stall held in REDIRECT for 3 cycles
    cycle(1, 0, 1, 0, 1, 32'h300, 32'h10);
    cycle(1, 1, 1, 0, 1, 32'h500, 32'h4);
    cycle(1, 1, 0, 0, 0, 32'h0, 32'h0);
    cycle(1, 1, 0, 0, 0, 32'h0, 32'h0);
    cycle(1, 0, 0, 0, 0, 32'h0, 32'h0);
    // Stall in IDLE with a mismatching branch
    cycle(1, 1, 1, 0, 1, 32'h600, 32'h4);
    cycle(1, 1, 1, 1, 1, 32'h600, 32'h4);
    cycle(1, 0, 0, 0, 0, 32'h0, 32'h0);
    // Saturate both counters
    for (int i = 0; i < 20; i++) begin
      cycle(1, 0, 1, 1, 0, 32'h1000 + 32'(i * 16), 32'h0);
      cycle(1, 0, 0, 0, 0, 32'h0, 32'h0);
    end
    // Reset during REDIRECT
    cycle(1, 0, 1, 0, 1, 32'h700, 32'h100);
    cycle(0, 0, 1, 0, 1, 32'h700, 32'h100);
    cycle(1, 0, 0, 0, 0, 32'h0, 32'h0);
    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      cycle(($urandom_range(0, 59) != 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 2) != 0), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : $urandom,
            $urandom);
    end
    @(posedge clk);
    #2;
    check("scoreboard_drained", longint'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
